register_file_param: RTL
========================

Name: register_file_param

Overview:
- Parametrised successor to the accumulator-style register file.
- Holds NREGS general registers plus one result register (res).
  - res is loaded from the ALU.
  - Values copy between res and a selected register in either direction.
- Adds three things the previous block lacked: synchronous reset, a same-cycle swap, and a multi-cycle clear sequence with a busy/done handshake.
- Sits between the ALU write-back path and the datapath operand mux.

Parameters:
- DATA_W, 16, width of every register, res and write_data.
- NREGS, 8, number of general registers (2..256).
- ADDR_W, 3, width of reg_sel; must satisfy 2**ADDR_W >= NREGS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cpyin  input  1  copy res into reg[reg_sel].
- cpyout  input  1  copy reg[reg_sel] into res.
- alu_we  input  1  load write_data into res.
- reg_sel  input  ADDR_W  register select for read, cpyin and cpyout.
- write_data  input  DATA_W  ALU result.
- clr_req  input  1  request to clear the whole file.
- res_val  output  DATA_W  current res contents.
- reg_val  output  DATA_W  current reg[reg_sel] contents; 0 if reg_sel >= NREGS.
- busy  output  1  high while the clear sequence runs.
- clr_done  output  1  one-cycle pulse on the final clear write.

Behaviour:
- Reset (reset=1 at the edge):
  - All reg[i] and res go to 0; state goes to IDLE; clear counter goes to 0.
  - busy=0, clr_done=0.
  - Reset has priority over every other input, including a clear in progress; reset mid-clear returns to IDLE with everything zeroed and no clr_done.
- Reads:
  - Combinational from current state; no write-to-read bypass.
  - A write at edge N is visible on res_val/reg_val after edge N.
- res update, IDLE only:
  - cpyout=1 and reg_sel < NREGS: res <= reg[reg_sel].
  - Otherwise, if alu_we=1: res <= write_data.
  - cpyout takes priority over alu_we.
  - cpyout with reg_sel >= NREGS: res <= 0, and alu_we is still ignored that cycle.
- Register update, IDLE only:
  - cpyin=1 and reg_sel < NREGS: reg[reg_sel] <= res, using the pre-edge value.
  - Writes with reg_sel >= NREGS are dropped silently.
- cpyin and cpyout together is a swap: reg[sel] gets the old res, res gets the old reg[sel].
- State machine, two states (IDLE, CLEAR):
  - IDLE -> CLEAR when clr_req=1. On that edge res <= 0 and the counter is loaded with 0. cpyin, cpyout and alu_we asserted in the same cycle as clr_req are dropped.
  - In CLEAR, each edge: reg[cnt] <= 0, cnt <= cnt+1.
  - When cnt == NREGS-1: write reg[NREGS-1] <= 0, assert clr_done for that cycle (registered, high the cycle after the last edge), return to IDLE.
  - busy=1 for exactly NREGS cycles, from the edge after clr_req until the edge returning to IDLE.
  - In CLEAR, cpyin, cpyout, alu_we and clr_req are ignored, not queued.
- Counter width is ADDR_W; it never wraps past NREGS-1.
- No arithmetic; all data paths are DATA_W bits with no extension or truncation.

Decomposition:
- Shared package register_file_pkg holds:
  - the state enum (IDLE, CLEAR);
  - a localparam helper for ADDR_W derivation;
  - a constant ZERO_WORD.
- One natural sub-module, rf_clear_seq:
  - contains the FSM, counter, busy and clr_done;
  - outputs clr_we and clr_idx to the storage array.
- Storage array and read mux stay in the top module.

Test Plan:
- reset; alu_we=1 with write_data=16'h1234; next cycle cpyin=1, reg_sel=3 -> res_val=1234 after edge 1; reg_val(sel=3)=1234 after edge 2.
- reg5=16'hAAAA, res=16'h5555; cpyin=cpyout=1, reg_sel=5 -> after one edge res_val=AAAA and reg5=5555 (swap).
- cpyout=1 and alu_we=1 in the same cycle, reg2=16'h0042, write_data=16'hFFFF -> res_val=0042.
- Fill all 8 registers with nonzero values; pulse clr_req:
  - busy high for exactly 8 cycles; clr_done high for 1 cycle;
  - all reg_val and res_val read 0;
  - an alu_we issued during busy does not change res.
- Assert reset on the 3rd cycle of CLEAR -> busy=0 on the next cycle, no clr_done pulse, all registers 0.
- NREGS=5, ADDR_W=3, reg_sel=6:
  - cpyin leaves all registers unchanged; reg_val=0;
  - cpyout sets res=0.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared types and constants for the parametrised register file and its clear sequencer.
package register_file_pkg;

  typedef enum logic {
    IDLE,
    CLEAR
  } rf_state_e;

  localparam int unsigned MAX_DATA_W = 256;
  localparam logic [MAX_DATA_W-1:0] ZERO_WORD = '0;

  // Smallest select width able to address nregs entries.
  function automatic int unsigned rf_addr_w(input int unsigned nregs);
    for (int unsigned w = 1; w < 32; w++) begin
      if ((32'd1 << w) >= nregs) return w;
    end
    return 32;
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks every register index once, then pulses done.
module rf_clear_seq
  import register_file_pkg::*;
#(
  parameter int unsigned NREGS  = 8,
  parameter int unsigned ADDR_W = rf_addr_w(NREGS)
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_clr_req,
  output logic              o_busy,
  output logic              o_clr_done,
  output logic              o_clr_start,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  rf_state_e         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic              r_done, w_done_nxt;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    o_clr_start = 1'b0;
    o_clr_we    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
          o_clr_start = 1'b1;
        end
      end
      CLEAR: begin
        o_clr_we = 1'b1;
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_busy     = (r_state == CLEAR);
  assign o_clr_done = r_done;
  assign o_clr_idx  = r_cnt;

endmodule

// File: rtl/register_file_param.sv
// Accumulator-style register file: NREGS general registers plus res, with swap and sequenced clear.
module register_file_param
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8,
  parameter int unsigned ADDR_W = rf_addr_w(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpyin,
  input  logic              cpyout,
  input  logic              alu_we,
  input  logic [ADDR_W-1:0] reg_sel,
  input  logic [DATA_W-1:0] write_data,
  input  logic              clr_req,
  output logic [DATA_W-1:0] res_val,
  output logic [DATA_W-1:0] reg_val,
  output logic              busy,
  output logic              clr_done
);

  localparam logic [DATA_W-1:0] ZW = ZERO_WORD[DATA_W-1:0];

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [DATA_W-1:0] r_res;
  logic              w_sel_ok;
  logic [DATA_W-1:0] w_sel_word;
  logic              w_busy;
  logic              w_clr_start;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_idx;

  rf_clear_seq #(
    .NREGS (NREGS),
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .clk        (clk),
    .i_reset    (reset),
    .i_clr_req  (clr_req),
    .o_busy     (w_busy),
    .o_clr_done (clr_done),
    .o_clr_start(w_clr_start),
    .o_clr_we   (w_clr_we),
    .o_clr_idx  (w_clr_idx)
  );

  assign w_sel_ok = (32'(reg_sel) < NREGS);

  always_comb begin
    w_sel_word = ZW;
    if (w_sel_ok) w_sel_word = r_regs[reg_sel];
  end

  // clr_we is high on every CLEAR cycle, so the final branch only runs in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= ZW;
      r_res <= ZW;
    end else if (w_clr_we) begin
      r_regs[w_clr_idx] <= ZW;
    end else if (w_clr_start) begin
      r_res <= ZW;
    end else begin
      if (cpyin && w_sel_ok) r_regs[reg_sel] <= r_res;
      if (cpyout)            r_res <= w_sel_word;
      else if (alu_we)       r_res <= write_data;
    end
  end

  assign res_val = r_res;
  assign reg_val = w_sel_word;
  assign busy    = w_busy;

endmodule
